// File: rtl/axi_slv_pkg.sv
// rtl/axi_slv_pkg.sv - shared encodings and byte-merge helper for the AXI write slave
package axi_slv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_slv_regfile.sv
// rtl/axi_slv_regfile.sv - 32-bit register storage with strobed write port and async read port
module axi_slv_regfile
  import axi_slv_pkg::*;
#(
  parameter int NUM_REGS = 256,
  parameter int IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic [31:0]      merged,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[widx] <= merged;
    end
  end

  // merged is also what the top reports as reg_wdata for this beat
  assign merged  = merge_strb(regs_q[widx], wdata, wstrb);
  assign rd_data = regs_q[rd_idx];

endmodule

// File: rtl/axi_write_slave.sv
// rtl/axi_write_slave.sv - AXI4 write-channel slave decoding bursts into a register bank
module axi_write_slave
  import axi_slv_pkg::*;
#(
  parameter int          ID_W      = 4,
  parameter logic [31:0] BASE_ADDR = 32'hE000A000,
  parameter int          NUM_REGS  = 256,
  parameter int          IDX_W     = 8
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_areset,
  input  logic [ID_W-1:0]  s00_axi_awid,
  input  logic [31:0]      s00_axi_awaddr,
  input  logic [7:0]       s00_axi_awlen,
  input  logic [2:0]       s00_axi_awsize,
  input  logic [1:0]       s00_axi_awburst,
  input  logic             s00_axi_awvalid,
  output logic             s00_axi_awready,
  input  logic [31:0]      s00_axi_wdata,
  input  logic [3:0]       s00_axi_wstrb,
  input  logic             s00_axi_wlast,
  input  logic             s00_axi_wvalid,
  output logic             s00_axi_wready,
  output logic [ID_W-1:0]  s00_axi_bid,
  output logic [1:0]       s00_axi_bresp,
  output logic             s00_axi_bvalid,
  input  logic             s00_axi_bready,
  output logic             reg_we,
  output logic [IDX_W-1:0] reg_idx,
  output logic [31:0]      reg_wdata,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_REGS);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d, bid_q, bid_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [7:0]       len_q, len_d, cnt_q, cnt_d;
  logic             fixed_q, fixed_d, nowr_q, nowr_d, err_q, err_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             reg_we_q, reg_we_d;
  logic [IDX_W-1:0] reg_idx_q, reg_idx_d;
  logic [31:0]      reg_wdata_q, reg_wdata_d;
  logic [31:0]      aw_off, merged;
  logic             aw_hs, w_hs, b_hs, beat_ok, last_beat;

  axi_slv_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_regfile (
    .clk     (s00_axi_aclk),
    .rst     (s00_axi_areset),
    .we      (w_hs && beat_ok),
    .widx    (idx_q[IDX_W-1:0]),
    .wdata   (s00_axi_wdata),
    .wstrb   (s00_axi_wstrb),
    .merged  (merged),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    aw_off      = s00_axi_awaddr - BASE_ADDR;
    aw_hs       = s00_axi_awvalid && awready_q;
    w_hs        = s00_axi_wvalid && wready_q;
    b_hs        = bvalid_q && s00_axi_bready;
    // the extra index bit lets an INCR burst walk off the top without aliasing
    beat_ok     = !nowr_q && (idx_q < (IDX_W+1)'(NUM_REGS));
    last_beat   = s00_axi_wlast || (cnt_q == len_q);
    state_d     = state_q;
    id_d        = id_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    fixed_d     = fixed_q;
    nowr_d      = nowr_q;
    err_d       = err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    reg_we_d    = 1'b0;
    reg_idx_d   = reg_idx_q;
    reg_wdata_d = reg_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d    = s00_axi_awid;
          len_d   = s00_axi_awlen;
          cnt_d   = 8'd0;
          fixed_d = (s00_axi_awburst == BURST_FIXED);
          idx_d   = aw_off[IDX_W+2:2];
          nowr_d  = (s00_axi_awsize != SIZE_4B)
                 || !(s00_axi_awburst == BURST_FIXED || s00_axi_awburst == BURST_INCR)
                 || (s00_axi_awaddr < BASE_ADDR) || (aw_off >= WIN_BYTES);
          err_d   = nowr_d;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (beat_ok) begin
            reg_we_d    = 1'b1;
            reg_idx_d   = idx_q[IDX_W-1:0];
            reg_wdata_d = merged;
          end else begin
            err_d = 1'b1;
          end
          if (s00_axi_wlast != (cnt_q == len_q)) err_d = 1'b1;
          if (!fixed_q) idx_d = idx_q + (IDX_W+1)'(1);
          cnt_d = cnt_q + 8'd1;
          if (last_beat) begin
            bid_d   = id_q;
            bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      fixed_q     <= 1'b0;
      nowr_q      <= 1'b0;
      err_q       <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_idx_q   <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      fixed_q     <= fixed_d;
      nowr_q      <= nowr_d;
      err_q       <= err_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      reg_we_q    <= reg_we_d;
      reg_idx_q   <= reg_idx_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bid     = bid_q;
  assign s00_axi_bresp   = bresp_q;
  assign reg_we          = reg_we_q;
  assign reg_idx         = reg_idx_q;
  assign reg_wdata       = reg_wdata_q;

endmodule

// File: tb/tb_axi_write_slave.sv
// tb/tb_axi_write_slave.sv - self-checking bench for axi_write_slave
module tb_axi_write_slave;

  localparam logic [31:0] BASE = 32'hE000A000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        reg_we;
  logic [7:0]  reg_idx;
  logic [31:0] reg_wdata;
  logic [7:0]  rd_idx = '0;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [256];

  axi_write_slave dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
    .s00_axi_awsize(awsize), .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wlast(wlast), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_wdata(reg_wdata), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_at;
    logic [31:0] data;
    logic [15:0] strbs;
    int          stall;
    logic [1:0]  bresp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] bt, input int i);
    return (bt == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  function automatic bit beat_legal(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bt);
    return (sz == 3'b010) && (bt <= 2'b01) && (a >= BASE) && (a < BASE + 32'd1024);
  endfunction

  function automatic int beats_of(input logic [7:0] len, input int wlast_at);
    return ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
  endfunction

  function automatic logic [1:0] model_bresp(input vec_t v);
    bit err = (v.wlast_at != int'(v.len));
    for (int i = 0; i < beats_of(v.len, v.wlast_at); i++)
      if (!beat_legal(beat_addr(v.addr, v.burst, i), v.size, v.burst)) err = 1;
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic wait_high(input string name, ref logic sig);
    int t = 0;
    while (sig !== 1'b1 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 40) chk({name, "_timeout"}, 32'(sig), 32'd1);
  endtask

  task automatic do_burst(input vec_t v);
    int nb = beats_of(v.len, v.wlast_at);
    logic [31:0] a, e;
    bit ok;
    @(posedge clk); #1;
    awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
    wait_high("awready", awready);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1;
      wdata  = v.data * 32'(i + 1);
      wstrb  = v.strbs[4*(i%4) +: 4];
      wlast  = (i == v.wlast_at);
      wait_high("wready", wready);
      @(posedge clk); #1;
      a  = beat_addr(v.addr, v.burst, i);
      ok = beat_legal(a, v.size, v.burst);
      chk("reg_we", 32'(reg_we), 32'(ok));
      if (ok) begin
        e = byte_merge(model[(a - BASE) >> 2], wdata, wstrb);
        model[(a - BASE) >> 2] = e;
        chk("reg_idx", 32'(reg_idx), (a - BASE) >> 2);
        chk("reg_wdata", reg_wdata, e);
      end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("bvalid_after_last", 32'(bvalid), 32'd1);
    chk("wready_in_resp", 32'(wready), 32'd0);
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk); #1;
      chk("bvalid_stall", 32'(bvalid), 32'd1);
      chk("awready_stall", 32'(awready), 32'd0);
    end
    chk("bid", 32'(bid), 32'(v.id));
    chk("bresp", 32'(bresp), 32'(v.bresp));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_done", 32'(bvalid), 32'd0);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 256; i++) begin
      rd_idx = 8'(i);
      #1;
      chk($sformatf("reg[%0h]", i), rd_data, model[i]);
    end
  endtask

  task automatic chk_reg(input logic [7:0] idx, input logic [31:0] exp);
    rd_idx = idx;
    #1;
    chk($sformatf("plan_reg[%0h]", idx), rd_data, exp);
  endtask

  vec_t tbl [12];
  vec_t rv;

  initial begin
    tbl[0]  = '{4'd0,  32'hE000A204, 8'd0, 3'b010, 2'b01, 0, 32'h0000FE01, 16'hFFFF, 0, 2'b00};
    tbl[1]  = '{4'd1,  32'hE000A208, 8'd0, 3'b010, 2'b01, 0, 32'h0000FE01, 16'hFFFF, 3, 2'b00};
    tbl[2]  = '{4'd2,  32'hE000A040, 8'd0, 3'b010, 2'b01, 0, 32'h00000001, 16'hFFFF, 0, 2'b00};
    tbl[3]  = '{4'd3,  32'hE000A044, 8'd0, 3'b010, 2'b01, 0, 32'hFFFFFFFF, 16'hFFFF, 0, 2'b00};
    tbl[4]  = '{4'd4,  32'hE000A040, 8'd3, 3'b010, 2'b01, 3, 32'h11111111, 16'hFF3F, 1, 2'b00};
    tbl[5]  = '{4'd5,  32'hE000A204, 8'd0, 3'b100, 2'b01, 0, 32'h12345678, 16'hFFFF, 0, 2'b10};
    tbl[6]  = '{4'd6,  32'hE000A3FC, 8'd1, 3'b010, 2'b01, 1, 32'hCAFE0001, 16'hFFFF, 0, 2'b10};
    tbl[7]  = '{4'd7,  32'hE000A100, 8'd2, 3'b010, 2'b01, 0, 32'h5555AAAA, 16'hFFFF, 0, 2'b10};
    tbl[8]  = '{4'd8,  32'hE0009FFC, 8'd0, 3'b010, 2'b01, 0, 32'hDEADBEEF, 16'hFFFF, 0, 2'b10};
    tbl[9]  = '{4'd9,  32'hE000A080, 8'd2, 3'b010, 2'b00, 2, 32'h01010101, 16'h0C13, 0, 2'b00};
    tbl[10] = '{4'd10, 32'hE000A0C0, 8'd1, 3'b010, 2'b10, 1, 32'h77777777, 16'hFFFF, 0, 2'b10};
    tbl[11] = '{4'd11, 32'hE000A0D0, 8'd1, 3'b010, 2'b01, 5, 32'h12121212, 16'hFFFF, 0, 2'b10};
    for (int i = 0; i < 256; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_bid_bresp", {bid, bresp}, 32'd0);
    chk("rst_reg_idx_wdata", reg_wdata | 32'(reg_idx), 32'd0);
    rst = 1'b0;

    // W before AW must stall
    @(posedge clk); #1;
    wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("w_before_aw_wready", 32'(wready), 32'd0);
    end
    wvalid = 1'b0;

    for (int i = 0; i < 12; i++) do_burst(tbl[i]);
    chk_reg(8'h81, 32'h0000FE01);
    chk_reg(8'h82, 32'h0000FE01);
    chk_reg(8'h10, 32'h11111111);
    chk_reg(8'h11, 32'hFFFF2222);
    chk_reg(8'h12, 32'h33333333);
    chk_reg(8'h13, 32'h44444444);
    chk_reg(8'hFF, 32'hCAFE0001);
    chk_reg(8'h20, 32'h03030102);
    compare_all();

    for (int r = 0; r < 40; r++) begin
      rv.id    = 4'($urandom);
      rv.len   = 8'($urandom_range(0, 5));
      case ($urandom % 8)
        6:       rv.addr = BASE + 32'(4 * $urandom_range(250, 255));
        7:       rv.addr = BASE + 32'(4 * $urandom_range(256, 270));
        default: rv.addr = BASE + 32'(4 * $urandom_range(0, 255));
      endcase
      rv.size     = ($urandom % 10 == 0) ? 3'b001 : 3'b010;
      rv.burst    = ($urandom % 10 == 0) ? 2'b10 : (($urandom % 3 == 0) ? 2'b00 : 2'b01);
      rv.wlast_at = ($urandom % 6 == 0) ? int'($urandom_range(0, 7)) : int'(rv.len);
      rv.data     = $urandom;
      rv.strbs    = 16'($urandom);
      rv.stall    = int'($urandom_range(0, 2));
      rv.bresp    = model_bresp(rv);
      do_burst(rv);
    end
    compare_all();

    // reset in the middle of a len 3 burst
    @(posedge clk); #1;
    awid = 4'd3; awaddr = 32'hE000A040; awlen = 8'd3; awsize = 3'b010; awburst = 2'b01;
    awvalid = 1'b1;
    wait_high("awready_rst", awready);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wlast = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_wready", 32'(wready), 32'd0);
    chk("midrst_awready", 32'(awready), 32'd0);
    chk("midrst_bvalid", 32'(bvalid), 32'd0);
    chk("midrst_reg_we", 32'(reg_we), 32'd0);
    chk("midrst_outs", reg_wdata | 32'(reg_idx) | 32'({bid, bresp}), 32'd0);
    for (int i = 0; i < 256; i++) model[i] = '0;
    chk_reg(8'h10, 32'd0);
    chk_reg(8'h81, 32'd0);
    wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("postrst_bvalid", 32'(bvalid), 32'd0);
    end
    do_burst(tbl[0]);
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
- AXI4 write-channel responder (slave) and register bank; the counterpart of the team's AXI write-initiator controllers.
- Accepts AW and W handshakes, decodes the address into a bank of 32-bit registers, and applies byte strobes.
- Returns one B response per burst, echoing the ID.
- Sits behind the interconnect at the peripheral window used by the controller's writes (0xE000A000 region).

Parameters:
- ID_W, 4, width of awid/bid.
- BASE_ADDR, 32'hE000A000, byte address of register 0.
- NUM_REGS, 256, number of 32-bit registers; window is BASE_ADDR .. BASE_ADDR+4*NUM_REGS-1.
- IDX_W, 8, register index width, equal to clog2(NUM_REGS).

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_areset  in  1  reset, asynchronous, active-high.
- s00_axi_awid  in  ID_W  write address ID.
- s00_axi_awaddr  in  32  byte address.
- s00_axi_awlen  in  8  beats minus 1.
- s00_axi_awsize  in  3  beat size.
- s00_axi_awburst  in  2  burst type.
- s00_axi_awvalid  in  1  AW valid.
- s00_axi_awready  out  1  AW ready.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wlast  in  1  final beat.
- s00_axi_wvalid  in  1  W valid.
- s00_axi_wready  out  1  W ready.
- s00_axi_bid  out  ID_W  response ID.
- s00_axi_bresp  out  2  response code.
- s00_axi_bvalid  out  1  B valid.
- s00_axi_bready  in  1  B ready.
- reg_we  out  1  one-cycle register-write pulse.
- reg_idx  out  IDX_W  index written.
- reg_wdata  out  32  merged register value after the write.
- rd_idx  in  IDX_W  debug read index.
- rd_data  out  32  combinational read of register rd_idx.

Behaviour:
- Interface: one clock, s00_axi_aclk. Reset s00_axi_areset is asynchronous and active-high.
- Reset values: state IDLE; awready, wready, bvalid, reg_we = 0; bid, bresp, reg_idx, reg_wdata = 0; all registers = 0.
- Ready signals are decoded from the registered state:
  - awready = 1 only in IDLE.
  - wready = 1 only in DATA.
  - bvalid = 1 only in RESP.
- The AWLOCK/CACHE/PROT/QOS signals are not implemented.
- States:
  - IDLE: on an AW handshake, latch id, index, len, size and burst; clear the beat counter and the error flag; go to DATA next cycle.
  - DATA: W is accepted only after AW; W before AW is legal AXI and simply stalls. Each W handshake:
    - if the beat is legal, reg[idx] is updated per byte where wstrb is set;
    - reg_we, reg_idx and reg_wdata are registered and visible the next cycle;
    - idx increments for INCR and holds for FIXED;
    - the beat counter increments.
    - Leave to RESP after the handshake where wlast=1 OR count==len, whichever comes first.
  - RESP: drive bid = latched id. bresp is 00 (OKAY) or 10 (SLVERR). Hold bvalid, bid and bresp stable until bready; go to IDLE the cycle after the B handshake.
- SLVERR conditions, sticky for the burst:
  - awsize != 3'b010: all beats accepted but no register written.
  - awburst is WRAP or reserved: same handling.
  - A beat whose address falls outside the window: that beat is suppressed, other beats are still written.
  - wlast disagrees with the beat count (early or late): burst ends at the first terminating event.
- Index arithmetic is IDX_W+1 bits wide, so an INCR burst running past the top of the window is detected as out of range. There is no wrap-around.
- Minimum cost is 1 (AW) + beats + 1 (B) cycles per burst. There is no outstanding-transaction overlap and a single ID is in flight.
- Simultaneous bready and awvalid in RESP: AW is not accepted until IDLE.
- Reset asserted mid-burst:
  - immediate return to IDLE with all outputs at their reset values;
  - registers are cleared;
  - no B response is issued for the aborted burst.

Decomposition:
- Package axi_slv_pkg:
  - state encoding IDLE/DATA/RESP;
  - BRESP codes OKAY=2'b00, SLVERR=2'b10;
  - burst codes FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - SIZE_4B=3'b010.
- Sub-module axi_slv_regfile holds the storage:
  - write port with idx, data and 4-bit strobes;
  - asynchronous clear;
  - combinational read port for rd_idx;
  - also returns the merged word that feeds reg_wdata.

Test Plan:
- Single write: awid=0, addr 0xE000A204, len 0, size 2, data 0x0000FE01, strb F -> reg[0x81]=0x0000FE01; reg_we pulse with idx 0x81; bid=0, bresp=00.
- Three back-to-back single writes (ids 0,1,2; addrs A204, A208, A040), with bready held low 3 cycles on the second -> bvalid/bid/bresp stable and awready=0 while stalled; reg[0x81]=reg[0x82]=0x0000FE01, reg[0x10]=1.
- INCR len 3 at 0xE000A040, data 0x11111111..0x44444444, beat 1 strb 0x3 over the prior value 0xFFFFFFFF -> regs 0x10..0x13 = 0x11111111, 0xFFFF2222, 0x33333333, 0x44444444; bresp=00.
- awsize=3'b100 single write to 0xE000A204 -> register unchanged, no reg_we, bresp=10.
- INCR len 1 at 0xE000A3FC -> reg[0xFF] written, second beat suppressed, bresp=10.
- Early wlast on beat 0 of len 2 -> burst ends, bresp=10.
- Reset pulse during DATA of a len 3 burst -> all outputs 0 and rd_data=0 for any idx; no bvalid; the following single write completes with OKAY.
